lcd_stream_buffer: RTL and testbench

Elastic pixel buffer that sits directly upstream of the RGB LCD timing driver. It accepts a valid/ready RGB888 pixel stream with start-of-frame marking, primes an internal FIFO, aligns the stream to the driver's first active pixel, and returns `pixel_data` one clock after each pixel coordinate request. It detects underflow and frame misalignment and resynchronises automatically.

---
 rtl/lcd_stream_buffer.sv | 168 ++++++++++++++++
 tb/tb_lcd_stream_buffer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_stream_buffer.sv
// lcd_stream_buffer: elastic RGB888 FIFO aligned to LCD timing; pixel_data 1 cycle after request, s_ready low when full/flushing.
// Optional LCD_STREAM_BUF_STATS_EN builds the saturating underflow/misalign counter on underflow_cnt.
module lcd_stream_buffer #(
  parameter int          DEPTH       = 1024,
  parameter int          PRIME_LEVEL = 512,
  parameter logic [23:0] FILL_COLOR  = 24'hFF00FF
) (
  input  logic                     lcd_pclk,
  input  logic                     rst,
  input  logic [23:0]              s_data,
  input  logic                     s_sof,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [10:0]              pixel_xpos,
  input  logic [10:0]              pixel_ypos,
  output logic [23:0]              pixel_data,
  output logic                     underflow,
  output logic                     misalign,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [15:0]              underflow_cnt
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_PRI = (AW+1)'(PRIME_LEVEL);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [1:0] {ST_SYNC, ST_FILL, ST_RUN, ST_FLUSH} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [24:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [23:0]   r_pixel;
  logic          r_underflow;
  logic          r_misalign;

  logic          w_req;
  logic          w_fs;
  logic          w_full;
  logic          w_empty;
  logic          w_primed;
  logic          w_push;
  logic          w_pop;
  logic          w_uf;
  logic          w_ma;
  logic          w_ready;
  logic [23:0]   w_pix_nxt;
  logic [24:0]   w_head;

  assign w_req    = (pixel_ypos != 11'd0);
  assign w_fs     = w_req && (pixel_xpos == 11'd0) && (pixel_ypos == 11'd1);
  assign w_full   = (r_count == CNT_MAX);
  assign w_empty  = (r_count == '0);
  assign w_primed = (r_count >= CNT_PRI);
  assign w_head   = r_mem[r_rd_ptr];

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_uf        = 1'b0;
    w_ma        = 1'b0;
    w_ready     = 1'b0;
    w_pix_nxt   = w_req ? FILL_COLOR : 24'd0;
    case (r_state)
      ST_SYNC: begin
        w_ready = 1'b1;
        if (s_valid && s_sof) begin
          w_push      = 1'b1;
          w_state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        w_ready = !w_full;
        w_push  = s_valid && !w_full;
        // Head is always the SOF word here, so the first pop needs no alignment check.
        if (w_fs && w_primed) begin
          w_pop       = 1'b1;
          w_pix_nxt   = w_head[23:0];
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_ready = !w_full;
        w_push  = s_valid && !w_full;
        if (w_req) begin
          if (w_empty) begin
            w_uf        = 1'b1;
            w_state_nxt = ST_FLUSH;
          end else begin
            w_pop = 1'b1;
            if (w_head[24] != w_fs) begin
              w_ma        = 1'b1;
              w_state_nxt = ST_FLUSH;
            end else begin
              w_pix_nxt = w_head[23:0];
            end
          end
        end
      end
      ST_FLUSH: begin
        w_state_nxt = ST_SYNC;
      end
      default: begin
        w_state_nxt = ST_SYNC;
      end
    endcase
  end

  always_ff @(posedge lcd_pclk) begin
    if (rst) begin
      r_state     <= ST_SYNC;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_pixel     <= '0;
      r_underflow <= 1'b0;
      r_misalign  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pixel     <= w_pix_nxt;
      r_underflow <= w_uf;
      r_misalign  <= w_ma;
      if (r_state == ST_FLUSH) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_ONE;
          2'b01:   r_count <= r_count - CNT_ONE;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge lcd_pclk) begin
    if (w_push) r_mem[r_wr_ptr] <= {s_sof, s_data};
  end

`ifdef LCD_STREAM_BUF_STATS_EN
  logic [15:0] r_ucnt;
  always_ff @(posedge lcd_pclk) begin
    if (rst) begin
      r_ucnt <= '0;
    end else if ((w_uf || w_ma) && (r_ucnt != 16'hFFFF)) begin
      r_ucnt <= r_ucnt + 16'd1;
    end
  end
  assign underflow_cnt = r_ucnt;
`else
  assign underflow_cnt = '0;
`endif

  assign s_ready    = w_ready;
  assign pixel_data = r_pixel;
  assign underflow  = r_underflow;
  assign misalign   = r_misalign;
  assign fill_level = r_count;

endmodule

// File: tb/tb_lcd_stream_buffer.sv
// Directed bench for lcd_stream_buffer with DEPTH=16, PRIME_LEVEL=4.
module tb_lcd_stream_buffer;

  logic        lcd_pclk = 1'b0;
  logic        rst;
  logic [23:0] s_data;
  logic        s_sof;
  logic        s_valid;
  logic        s_ready;
  logic [10:0] pixel_xpos;
  logic [10:0] pixel_ypos;
  logic [23:0] pixel_data;
  logic        underflow;
  logic        misalign;
  logic [4:0]  fill_level;
  logic [15:0] underflow_cnt;

  int tests = 0;
  int fails = 0;

  localparam logic [23:0] FC = 24'hFF00FF;

  lcd_stream_buffer #(.DEPTH(16), .PRIME_LEVEL(4), .FILL_COLOR(24'hFF00FF)) dut (
    .lcd_pclk      (lcd_pclk),
    .rst           (rst),
    .s_data        (s_data),
    .s_sof         (s_sof),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .pixel_xpos    (pixel_xpos),
    .pixel_ypos    (pixel_ypos),
    .pixel_data    (pixel_data),
    .underflow     (underflow),
    .misalign      (misalign),
    .fill_level    (fill_level),
    .underflow_cnt (underflow_cnt)
  );

  always #5 lcd_pclk = ~lcd_pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the edge.
  task automatic step(input logic r, input logic v, input logic sof, input logic [23:0] d,
                      input logic [10:0] x, input logic [10:0] y);
    rst        = r;
    s_valid    = v;
    s_sof      = sof;
    s_data     = d;
    pixel_xpos = x;
    pixel_ypos = y;
    @(posedge lcd_pclk);
    #1;
  endtask

  task automatic push(input logic sof, input logic [23:0] d);
    step(1'b0, 1'b1, sof, d, 11'd0, 11'd0);
  endtask

  task automatic req(input logic [10:0] x, input logic [10:0] y);
    step(1'b0, 1'b0, 1'b0, 24'd0, x, y);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 24'd0, 11'd0, 11'd0);
  endtask

  logic [15:0] exp_cnt1;
  logic [15:0] exp_cnt2;

  initial begin
`ifdef LCD_STREAM_BUF_STATS_EN
    exp_cnt1 = 16'd1;
    exp_cnt2 = 16'd2;
`else
    exp_cnt1 = 16'd0;
    exp_cnt2 = 16'd0;
`endif
    // Reset state
    step(1'b1, 1'b0, 1'b0, 24'd0, 11'd0, 11'd0);
    step(1'b1, 1'b0, 1'b0, 24'd0, 11'd0, 11'd0);
    check("rst_fill", 32'(fill_level), 32'd0);
    check("rst_pix", 32'(pixel_data), 32'd0);
    check("rst_rdy", 32'(s_ready), 32'd1);
    check("rst_uf", 32'(underflow), 32'd0);
    check("rst_ma", 32'(misalign), 32'd0);
    check("rst_cnt", 32'(underflow_cnt), 32'd0);

    // Prime and align: 4x2 frame, data 1..8
    for (int i = 1; i <= 8; i++) push(i == 1, 24'(i));
    check("prime_fill", 32'(fill_level), 32'd8);
    for (int i = 0; i < 8; i++) begin
      req(11'(i % 4), 11'(1 + i / 4));
      check("align_pix", 32'(pixel_data), 32'(i + 1));
      check("align_pulse", 32'({underflow, misalign}), 32'd0);
    end
    idle();
    check("noreq_pix", 32'(pixel_data), 32'd0);
    check("drain_fill", 32'(fill_level), 32'd0);

    // Underflow on empty FIFO
    req(11'd0, 11'd3);
    check("uf_pix", 32'(pixel_data), 32'(FC));
    check("uf_pulse", 32'(underflow), 32'd1);
    check("uf_cnt", 32'(underflow_cnt), 32'(exp_cnt1));
    check("flush_rdy", 32'(s_ready), 32'd0);
    idle();
    check("uf_once", 32'(underflow), 32'd0);
    check("sync_rdy", 32'(s_ready), 32'd1);
    check("sync_fill", 32'(fill_level), 32'd0);

    // Junk before SOF is dropped
    push(1'b0, 24'hAAA001);
    push(1'b0, 24'hAAA002);
    push(1'b0, 24'hAAA003);
    check("junk_fill", 32'(fill_level), 32'd0);
    push(1'b1, 24'h000100);
    push(1'b0, 24'h000101);
    push(1'b0, 24'h000102);
    // Not yet primed: request returns fill colour and pops nothing
    req(11'd0, 11'd1);
    check("unprimed_pix", 32'(pixel_data), 32'(FC));
    check("unprimed_fill", 32'(fill_level), 32'd3);
    for (int i = 3; i < 8; i++) push(1'b0, 24'h000100 + 24'(i));
    check("junk_fill8", 32'(fill_level), 32'd8);
    req(11'd0, 11'd1);
    check("junk_first", 32'(pixel_data), 32'h000100);
    req(11'd1, 11'd1);
    check("junk_second", 32'(pixel_data), 32'h000101);

    // Reset mid-line
    step(1'b1, 1'b0, 1'b0, 24'd0, 11'd2, 11'd1);
    check("mrst_fill", 32'(fill_level), 32'd0);
    check("mrst_pix", 32'(pixel_data), 32'd0);
    check("mrst_rdy", 32'(s_ready), 32'd1);
    check("mrst_cnt", 32'(underflow_cnt), 32'd0);

    // Misalignment: SOF at stream position 2
    push(1'b1, 24'h000200);
    push(1'b0, 24'h000201);
    push(1'b1, 24'h000202);
    push(1'b0, 24'h000203);
    req(11'd0, 11'd1);
    check("ma_p0", 32'(pixel_data), 32'h000200);
    req(11'd1, 11'd1);
    check("ma_p1", 32'(pixel_data), 32'h000201);
    req(11'd2, 11'd1);
    check("ma_pix", 32'(pixel_data), 32'(FC));
    check("ma_pulse", 32'({underflow, misalign}), 32'd1);
    check("ma_cnt", 32'(underflow_cnt), 32'(exp_cnt1));
    check("ma_flush_rdy", 32'(s_ready), 32'd0);
    idle();
    check("ma_sync_fill", 32'(fill_level), 32'd0);
    check("ma_once", 32'(misalign), 32'd0);

    // Fill to DEPTH with no requests
    for (int i = 0; i < 16; i++) push(i == 0, 24'h000300 + 24'(i));
    check("full_fill", 32'(fill_level), 32'd16);
    check("full_rdy", 32'(s_ready), 32'd0);
    push(1'b0, 24'h0003FF);
    check("full_hold", 32'(fill_level), 32'd16);

    // Pop while full, then simultaneous push and pop
    step(1'b0, 1'b1, 1'b0, 24'h000310, 11'd0, 11'd1);
    check("fpop_pix", 32'(pixel_data), 32'h000300);
    check("fpop_fill", 32'(fill_level), 32'd15);
    step(1'b0, 1'b1, 1'b0, 24'h000310, 11'd1, 11'd1);
    check("pp1_pix", 32'(pixel_data), 32'h000301);
    check("pp1_fill", 32'(fill_level), 32'd15);
    step(1'b0, 1'b1, 1'b0, 24'h000311, 11'd2, 11'd1);
    check("pp2_pix", 32'(pixel_data), 32'h000302);
    check("pp2_fill", 32'(fill_level), 32'd15);
    check("pp_cnt", 32'(underflow_cnt), 32'(exp_cnt1));
    check("pp_cnt_ref", 32'(exp_cnt2), 32'(exp_cnt1) * 32'd2);

    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
